// File: rtl/twin_reg_serializer.sv
// Twin register read-out serializer.
// On an accepted start, captures d1/d2 and sends them as one 2*WIDTH-bit frame
// (d1 first, then d2) over a valid/ready bit stream. done pulses once per completed frame.
module twin_reg_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             start,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FrameLen = 2 * WIDTH;
    localparam int unsigned CntW     = $clog2(FrameLen);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [FrameLen-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  last_bit;

    assign accept   = (state_q == StShift) && sout_ready;
    assign last_bit = (cnt_q == CntW'(FrameLen - 1));

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only counts in idle, leave shift on the final accepted bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (accept && last_bit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: load, shift on accept, raise done after the last bit.
    // The shift register is arranged so the outgoing bit is always at one fixed end:
    // MSB-first loads {d1,d2} and shifts left, LSB-first loads {d2,d1} and shifts right.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                shreg_d = MSB_FIRST ? {d1, d2} : {d2, d1};
                cnt_d   = '0;
            end
        end else if (accept) begin
            if (last_bit) begin
                shreg_d = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                shreg_d = MSB_FIRST ? {shreg_q[FrameLen-2:0], 1'b0}
                                    : {1'b0, shreg_q[FrameLen-1:1]};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs decoded from state; sout is forced low whenever no bit is presented.
    always_comb begin
        sout_valid = (state_q == StShift);
        busy       = (state_q == StShift);
        done       = done_q;
        sout       = 1'b0;
        if (state_q == StShift) begin
            sout = MSB_FIRST ? shreg_q[FrameLen-1] : shreg_q[0];
        end
    end

endmodule

// File: tb/tb_twin_reg_serializer.sv
// Self-checking bench for twin_reg_serializer: one MSB-first and one LSB-first instance
// share stimulus; a frame-index model predicts every output each cycle.
module tb_twin_reg_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d1, d2;
    logic         start;
    logic         sout_ready;
    logic         sout_m, valid_m, busy_m, done_m;
    logic         sout_l, valid_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    twin_reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .d1(d1), .d2(d2), .start(start),
        .sout(sout_m), .sout_valid(valid_m), .sout_ready(sout_ready),
        .busy(busy_m), .done(done_m)
    );

    twin_reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .d1(d1), .d2(d2), .start(start),
        .sout(sout_l), .sout_valid(valid_l), .sout_ready(sout_ready),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit idx (0 = first sent) of the frame built from words a then b.
    function automatic logic exp_bit(input bit msb, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input int idx);
        logic [W-1:0] w;
        int p;
        w = (idx < W) ? a : b;
        p = idx % W;
        return msb ? w[W-1-p] : w[p];
    endfunction

    // Whole frame with the first-sent bit at the MSB.
    function automatic logic [2*W-1:0] frame_of(input bit msb, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] f;
        f = '0;
        for (int i = 0; i < 2 * W; i++) f = {f[2*W-2:0], exp_bit(msb, a, b, i)};
        return f;
    endfunction

    // Behavioural model: frame active flag, index of the bit on the wire, captured words.
    logic         m_act = 1'b0;
    int           m_idx = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_d1 = '0, m_d2 = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_idx  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_act) begin
                if (start) begin
                    m_act <= 1'b1;
                    m_idx <= 0;
                    m_d1  <= d1;
                    m_d2  <= d2;
                end
            end else if (sout_ready) begin
                if (m_idx == 2 * W - 1) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    // Last 2*W accepted bits of each DUT, first-accepted at the MSB.
    logic [2*W-1:0] cap_m = '0, cap_l = '0;
    always @(posedge clk) begin
        if (valid_m && sout_ready) cap_m <= {cap_m[2*W-2:0], sout_m};
        if (valid_l && sout_ready) cap_l <= {cap_l[2*W-2:0], sout_l};
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(valid_m), 32'(m_act));
            chk("m_busy",  32'(busy_m),  32'(m_act));
            chk("m_done",  32'(done_m),  32'(m_done));
            chk("m_sout",  32'(sout_m),  32'(m_act ? exp_bit(1'b1, m_d1, m_d2, m_idx) : 1'b0));
            chk("l_valid", 32'(valid_l), 32'(m_act));
            chk("l_busy",  32'(busy_l),  32'(m_act));
            chk("l_done",  32'(done_l),  32'(m_done));
            chk("l_sout",  32'(sout_l),  32'(m_act ? exp_bit(1'b0, m_d1, m_d2, m_idx) : 1'b0));
        end
    end

    // Counts negedges from the current one until done_m is seen; -1 if it never is.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 80; k++) begin
            if (done_m) begin
                n = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done_m) n++;
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        d1    = a;
        d2    = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int   n;
    logic s0;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sout_ready = 1'b1;
        d1         = '0;
        d2         = '0;

        // Model pinned against hand-derived frames.
        chk("model_aa55_msb", 32'(frame_of(1'b1, 8'hAA, 8'h55)), 32'h0000AA55);
        chk("model_aa55_lsb", 32'(frame_of(1'b0, 8'hAA, 8'h55)), 32'h000055AA);
        chk("model_0ff0_msb", 32'(frame_of(1'b1, 8'h0F, 8'hF0)), 32'h00000FF0);

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_m), 32'd0);
        chk("rst_busy",  32'(busy_m),  32'd0);
        chk("rst_done",  32'(done_m),  32'd0);
        chk("rst_sout",  32'(sout_m),  32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Plain frame, ready held high.
        pulse_start(8'hAA, 8'h55);
        wait_done(n);
        chk("t1_done_cycle", 32'(n), 32'd17);
        chk("t1_stream_msb", 32'(cap_m), 32'h0000AA55);
        chk("t1_stream_lsb", 32'(cap_l), 32'h000055AA);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy_m), 32'd0);

        // Three-cycle stall on the 5th bit.
        pulse_start(8'hAA, 8'h55);
        repeat (4) @(negedge clk);
        sout_ready = 1'b0;
        s0 = sout_m;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_valid", 32'(valid_m), 32'd1);
            chk("t2_stall_sout",  32'(sout_m),  32'(s0));
        end
        sout_ready = 1'b1;
        wait_done(n);
        chk("t2_done_cycle", 32'(n), 32'd13);
        chk("t2_stream_msb", 32'(cap_m), 32'h0000AA55);

        // Start while busy is ignored.
        pulse_start(8'hAA, 8'h55);
        repeat (3) @(negedge clk);
        pulse_start(8'hFF, 8'hFF);
        wait_done(n);
        chk("t3_done_seen", 32'(n > 0), 32'd1);
        chk("t3_stream_msb", 32'(cap_m), 32'h0000AA55);
        count_done(20, n);
        chk("t3_extra_done", 32'(n), 32'd0);

        // Reset on the 7th bit aborts the frame.
        pulse_start(8'hAA, 8'h55);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_valid", 32'(valid_m), 32'd0);
        chk("t4_busy",  32'(busy_m),  32'd0);
        chk("t4_sout",  32'(sout_m),  32'd0);
        count_done(20, n);
        chk("t4_no_done", 32'(n), 32'd0);
        pulse_start(8'hAA, 8'h55);
        wait_done(n);
        chk("t4_refr_cycle", 32'(n), 32'd17);
        chk("t4_refr_stream", 32'(cap_m), 32'h0000AA55);

        // Start held through the done cycle gives back-to-back frames with one gap.
        d1    = 8'h0F;
        d2    = 8'hF0;
        start = 1'b1;
        @(negedge clk);
        wait_done(n);
        chk("t5_first_cycle", 32'(n), 32'd17);
        chk("t5_gap_valid", 32'(valid_m), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("t5_second_valid", 32'(valid_m), 32'd1);
        wait_done(n);
        chk("t5_second_cycle", 32'(n), 32'd17);
        chk("t5_stream_msb", 32'(cap_m), 32'h00000FF0);
        chk("t5_stream_lsb", 32'(cap_l), 32'h0000F00F);

        // Random traffic: stalls, starts, data churn, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            sout_ready = ($urandom % 10) < 7;
            start      = ($urandom % 8) == 0;
            d1         = W'($urandom);
            d2         = W'($urandom);
            rst        = ($urandom % 100) == 0;
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
